// File: rtl/cache_2way.sv
// Two-way set-associative write-back cache: 8 sets, 128-bit lines, 16-bit CPU words.
// Hits complete combinationally in IDLE; misses optionally write back the victim, then refill.
module cache_2way (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_wmask,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0][7:0] valid_q, valid_d;
    logic [1:0][7:0] dirty_q, dirty_d;
    logic [7:0]      lru_q, lru_d;
    logic            victim_q, victim_d;
    logic [11:0]     line_q, line_d;

    logic [8:0]   tag_mem  [2][8];
    logic [127:0] data_mem [2][8];

    logic [8:0]   req_tag;
    logic [2:0]   req_idx;
    logic [2:0]   req_off;
    logic [6:0]   word_lsb;
    logic         addr_byte_unused;

    assign req_tag          = mem_address[15:7];
    assign req_idx          = mem_address[6:4];
    assign req_off          = mem_address[3:1];
    assign word_lsb         = {req_off, 4'b0000};
    assign addr_byte_unused = mem_address[0];

    logic [1:0]   way_hit;
    logic [127:0] way_line [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign way_hit[gi]  = valid_q[gi][req_idx] && (tag_mem[gi][req_idx] == req_tag);
            assign way_line[gi] = data_mem[gi][req_idx];
        end
    endgenerate

    logic         hit;
    logic         hit_way;
    logic [127:0] hit_line;
    logic [127:0] merged_line;
    logic         victim_sel;
    logic [2:0]   fill_idx;
    logic [8:0]   fill_tag;

    assign hit       = |way_hit;
    assign hit_way   = way_hit[1];
    assign hit_line  = way_line[hit_way];
    assign mem_rdata = hit_line[word_lsb +: 16];

    // The miss line is captured on entry so a dropped request cannot redirect the fill.
    assign fill_idx   = line_q[2:0];
    assign fill_tag   = line_q[11:3];
    assign pmem_wdata = data_mem[victim_q][fill_idx];

    always_comb begin
        merged_line = hit_line;
        if (mem_wmask[0]) merged_line[word_lsb +: 8]         = mem_wdata[7:0];
        if (mem_wmask[1]) merged_line[word_lsb + 7'd8 +: 8]  = mem_wdata[15:8];
    end

    always_comb begin
        if (!valid_q[0][req_idx])      victim_sel = 1'b0;
        else if (!valid_q[1][req_idx]) victim_sel = 1'b1;
        else                           victim_sel = lru_q[req_idx];
    end

    logic hit_wr;
    logic fill_wr;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lru_d        = lru_q;
        victim_d     = victim_q;
        line_d       = line_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        hit_wr       = 1'b0;
        fill_wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    if (hit) begin
                        mem_resp       = 1'b1;
                        lru_d[req_idx] = ~hit_way;
                        if (mem_write) begin
                            hit_wr                   = 1'b1;
                            dirty_d[hit_way][req_idx] = 1'b1;
                        end
                    end else begin
                        victim_d = victim_sel;
                        line_d   = mem_address[15:4];
                        if (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
                            state_d = S_WRITEBACK;
                        else
                            state_d = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_mem[victim_q][fill_idx], fill_idx, 4'b0000};
                if (pmem_resp) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {line_q, 4'b0000};
                if (pmem_resp) begin
                    fill_wr                     = 1'b1;
                    valid_d[victim_q][fill_idx] = 1'b1;
                    dirty_d[victim_q][fill_idx] = 1'b0;
                    state_d                     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
            victim_q <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
            line_q   <= line_d;
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_mem[victim_q][fill_idx] <= pmem_rdata;
            tag_mem[victim_q][fill_idx]  <= fill_tag;
        end else if (hit_wr) begin
            data_mem[hit_way][req_idx] <= merged_line;
        end
    end

endmodule

// File: tb/tb_cache_2way.sv
// Self-checking bench for cache_2way: table of CPU requests against a latency-3 memory model,
// plus a hand-written reset-during-refill sequence.
module tb_cache_2way;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_wmask;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cache_2way dut (
        .clk          (clk),
        .reset        (reset),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  mask;
        logic [15:0] wdata;
        int          fills;
        int          wbs;
        logic [15:0] fill_addr;
        logic [15:0] wb_addr;
        int          cycles;
        logic [15:0] exp_rdata;
    } vec_t;

    logic [127:0] mem_model [4096];
    logic [127:0] ref_line  [4096];
    logic [15:0]  exp_q [$];

    int checks = 0;
    int errors = 0;
    int fill_cnt = 0;
    int wb_cnt = 0;
    int overlap_cnt = 0;
    int lat_cnt = 0;
    int manual_req = 0;
    int manual_done = 0;
    bit auto_mem = 1'b0;
    logic [15:0]  last_fill_addr = 16'h0;
    logic [15:0]  last_wb_addr = 16'h0;
    logic [127:0] last_wb_data = '0;

    // Physical memory: answers each pmem request three cycles after it appears.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) overlap_cnt++;
            if (manual_req != manual_done) begin
                pmem_rdata  = {8{16'hDEAD}};
                pmem_resp   = 1'b1;
                manual_done = manual_done + 1;
            end else if (auto_mem && (pmem_read || pmem_write)) begin
                lat_cnt++;
                if (lat_cnt == 3) begin
                    lat_cnt = 0;
                    if (pmem_write) begin
                        wb_cnt++;
                        last_wb_addr = pmem_address;
                        last_wb_data = pmem_wdata;
                        mem_model[pmem_address[15:4]] = pmem_wdata;
                    end else begin
                        fill_cnt++;
                        last_fill_addr = pmem_address;
                        pmem_rdata = mem_model[pmem_address[15:4]];
                    end
                    pmem_resp = 1'b1;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic chk_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic ref_write(input logic [15:0] a, input logic [1:0] m, input logic [15:0] d);
        logic [127:0] l;
        int lsb;
        l   = ref_line[a[15:4]];
        lsb = 16 * int'(a[3:1]);
        if (m[0]) l[lsb +: 8]     = d[7:0];
        if (m[1]) l[lsb + 8 +: 8] = d[15:8];
        ref_line[a[15:4]] = l;
    endtask

    function automatic vec_t mk(input logic [15:0] addr, input logic rd, input logic wr,
                                input logic [1:0] mask, input logic [15:0] wdata,
                                input int fills, input int wbs, input logic [15:0] fa,
                                input logic [15:0] wa, input int cyc, input logic [15:0] er);
        vec_t v;
        v.addr = addr; v.rd = rd; v.wr = wr; v.mask = mask; v.wdata = wdata;
        v.fills = fills; v.wbs = wbs; v.fill_addr = fa; v.wb_addr = wa;
        v.cycles = cyc; v.exp_rdata = er;
        return v;
    endfunction

    // Called just after a rising edge; returns just after a rising edge with the bus idle.
    task automatic run_vec(input vec_t v, input int n);
        int f0, w0, cyc;
        bit done;
        logic [15:0] e;
        f0 = fill_cnt;
        w0 = wb_cnt;
        mem_address = v.addr;
        mem_read    = v.rd;
        mem_write   = v.wr;
        mem_wmask   = v.mask;
        mem_wdata   = v.wdata;
        if (v.rd && !v.wr) exp_q.push_back(v.exp_rdata);
        if (v.wr) ref_write(v.addr, v.mask, v.wdata);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) begin
                done = 1'b1;
                if (mem_read && !mem_write) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL row%0d unexpected read response rdata=%0h", n, mem_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk_vec($sformatf("row%0d rdata", n), 128'(mem_rdata), 128'(e));
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL row%0d timeout got=no mem_resp exp=mem_resp", n);
            void'(exp_q.pop_back());
        end
        chk_int($sformatf("row%0d latency", n), cyc, v.cycles);
        chk_int($sformatf("row%0d fills", n), fill_cnt - f0, v.fills);
        chk_int($sformatf("row%0d writebacks", n), wb_cnt - w0, v.wbs);
        if (v.fills > 0)
            chk_vec($sformatf("row%0d fill_addr", n), 128'(last_fill_addr), 128'(v.fill_addr));
        if (v.wbs > 0) begin
            chk_vec($sformatf("row%0d wb_addr", n), 128'(last_wb_addr), 128'(v.wb_addr));
            chk_vec($sformatf("row%0d wb_data", n), last_wb_data, ref_line[v.wb_addr[15:4]]);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk_vec($sformatf("row%0d idle outputs", n), 128'({mem_resp, pmem_read, pmem_write}), 128'(3'b000));
        $display("row %0d addr=%h rd=%0d wr=%0d cycles=%0d fills=%0d wbs=%0d",
                 n, v.addr, v.rd, v.wr, cyc, fill_cnt - f0, wb_cnt - w0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [18];
    vec_t post [2];

    initial begin
        int cyc, bad;
        for (int la = 0; la < 4096; la++) begin
            for (int w = 0; w < 8; w++) begin
                mem_model[la][w*16 +: 16] = {la[11:0], 1'b0, w[2:0]};
            end
        end
        mem_model[12'h123][63:48] = 16'hBEEF;
        for (int la = 0; la < 4096; la++) ref_line[la] = mem_model[la];

        //              addr     rd  wr  mask   wdata    f  wb  fill     wb       cyc exp
        vecs[0]  = mk(16'h1236, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h1230, 16'h0000, 5, 16'hBEEF);
        vecs[1]  = mk(16'h1236, 0, 1, 2'b01, 16'h00AA, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
        vecs[2]  = mk(16'h1236, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEAA);
        vecs[3]  = mk(16'h12B0, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h12B0, 16'h0000, 5, 16'h12B0);
        vecs[4]  = mk(16'h1236, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEAA);
        vecs[5]  = mk(16'h1330, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h1330, 16'h0000, 5, 16'h1330);
        vecs[6]  = mk(16'h13B2, 1, 0, 2'b00, 16'h0000, 1, 1, 16'h13B0, 16'h1230, 8, 16'h13B1);
        vecs[7]  = mk(16'h1236, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h1230, 16'h0000, 5, 16'hBEAA);
        vecs[8]  = mk(16'h1236, 1, 1, 2'b11, 16'h1357, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
        vecs[9]  = mk(16'h1236, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h1357);
        vecs[10] = mk(16'h13B2, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h13B1);
        vecs[11] = mk(16'h1334, 0, 1, 2'b10, 16'hAB00, 1, 1, 16'h1330, 16'h1230, 8, 16'h0000);
        vecs[12] = mk(16'h1334, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hAB32);
        vecs[13] = mk(16'h0042, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0040, 16'h0000, 5, 16'h0041);
        vecs[14] = mk(16'h0042, 0, 1, 2'b00, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
        vecs[15] = mk(16'h0042, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h0041);
        vecs[16] = mk(16'h1330, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h1330);
        vecs[17] = mk(16'h12B0, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h12B0, 16'h0000, 5, 16'h12B0);
        post[0]  = mk(16'h5550, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h5550, 16'h0000, 5, 16'h5550);
        post[1]  = mk(16'h1236, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h1230, 16'h0000, 5, 16'h1357);

        reset       = 1'b1;
        mem_address = 16'h0000;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = 2'b00;
        mem_wdata   = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk_vec("reset outputs", 128'({mem_resp, pmem_read, pmem_write}), 128'(3'b000));
        reset    = 1'b0;
        auto_mem = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Reset in the middle of a refill, then a stale pmem_resp after release.
        auto_mem    = 1'b0;
        mem_address = 16'h5550;
        mem_read    = 1'b1;
        cyc = 0;
        while (!pmem_read && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk_vec("alloc pmem_read", 128'(pmem_read), 128'(1'b1));
        chk_vec("alloc pmem_address", 128'(pmem_address), 128'(16'h5550));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_vec("async reset outputs", 128'({mem_resp, pmem_read, pmem_write}), 128'(3'b000));
        @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_read   = 1'b0;
        manual_req = manual_req + 1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_resp || pmem_read || pmem_write) bad++;
        end
        chk_int("late pmem_resp delivered", manual_done, manual_req);
        chk_int("late pmem_resp ignored", bad, 0);
        $display("reset-during-allocate sequence done, stray activity cycles=%0d", bad);
        for (int la = 0; la < 4096; la++) ref_line[la] = mem_model[la];
        auto_mem = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) run_vec(post[i], 100 + i);

        chk_int("pmem read/write overlap", overlap_cnt, 0);
        chk_int("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
